phase_sequencer: RTL

- Parametrised multi-cycle CPU phase generator, successor to the fixed 5-phase one-hot ring.
- Drives one-hot phase enables (IF, ID, ALU, MEM, BR, … for default config) for the datapath stages.
- Adds:
  - configurable phase count;
  - per-instruction phase skipping;
  - stall;
  - flush-to-fetch;
  - binary phase index;
  - retire/cycle accounting.
- Sits between the top-level clock and the stage controllers.

---
 rtl/phase_sequencer_pkg.sv | 21 ++
 rtl/phase_next_sel.sv | 34 +++
 rtl/phase_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/phase_sequencer_pkg.sv
// cpu_seq_pkg: definitions shared by the phase sequencer and its next-phase finder.
//   DEF_NUM_PHASES : default length of the phase ring.
//   PH_*           : named phase indices for the default five-phase CPU.
//   idx_width()    : width of the binary phase index for a given ring length.
package cpu_seq_pkg;

  localparam int DEF_NUM_PHASES = 5;

  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_ALU = 2;
  localparam int PH_MEM = 3;
  localparam int PH_BR  = 4;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_NUM_PHASES);

endpackage

// File: rtl/phase_next_sel.sv
// phase_next_sel: combinational priority finder for the next phase.
//   cur_idx   : current binary phase index.
//   skip_mask : bit k set means phase k is bypassed; bit 0 is not used
//               because fetch can never be skipped.
//   next_idx  : smallest phase q > cur_idx whose skip bit is clear, else 0.
//   wrap      : 1 when no such phase exists and the ring returns to fetch.
module phase_next_sel
  import cpu_seq_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int IDX_W      = idx_width(NUM_PHASES)
) (
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic [NUM_PHASES-1:0] skip_mask,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  wrap
);

  logic unused_skip0;
  assign unused_skip0 = skip_mask[0];

  // Scan from the top down so the lowest qualifying phase is the last write.
  always_comb begin
    next_idx = '0;
    wrap     = 1'b1;
    for (int q = NUM_PHASES - 1; q >= 1; q--) begin
      if ((q > int'(cur_idx)) && !skip_mask[q]) begin
        next_idx = IDX_W'(q);
        wrap     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: parametrised multi-cycle CPU phase generator.
//   clk, reset   : clock and asynchronous active-high reset.
//   enable       : global run; low freezes all state.
//   stall        : hold the current phase this cycle.
//   flush        : abandon the current instruction and return to fetch.
//   skip_mask    : per-phase bypass bits sampled on advancing edges.
//   phase_oh     : one-hot current phase (always 1 << phase_idx).
//   phase_idx    : binary current phase.
//   instr_start  : first cycle in phase 0 of a new instruction.
//   instr_done   : instruction retired by wrapping to phase 0.
//   retired_cnt  : retired-instruction counter, wraps.
//   instr_cycles : cycles spent in the current instruction, saturating.
module phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter  int NUM_PHASES = DEF_NUM_PHASES,
  parameter  int CNT_W      = 32,
  parameter  int CYC_W      = 8,
  localparam int IDX_W      = idx_width(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NUM_PHASES-1:0] skip_mask,
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  instr_start,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [CYC_W-1:0]      instr_cycles
);

  logic [IDX_W-1:0] next_idx;
  logic             wrap;

  function automatic logic [NUM_PHASES-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_PHASES-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  phase_next_sel #(
    .NUM_PHASES (NUM_PHASES),
    .IDX_W      (IDX_W)
  ) u_next_sel (
    .cur_idx   (phase_idx),
    .skip_mask (skip_mask),
    .next_idx  (next_idx),
    .wrap      (wrap)
  );

  // phase_idx is the real state; phase_oh is decoded from the same next index
  // on the same edge, so the two can never disagree or leave one-hot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_idx    <= '0;
      phase_oh     <= onehot('0);
      instr_start  <= 1'b1;
      instr_done   <= 1'b0;
      retired_cnt  <= '0;
      instr_cycles <= '0;
    end else if (!enable) begin
      instr_start <= 1'b0;
      instr_done  <= 1'b0;
    end else if (flush) begin
      phase_idx    <= '0;
      phase_oh     <= onehot('0);
      instr_start  <= 1'b1;
      instr_done   <= 1'b0;
      instr_cycles <= '0;
    end else if (stall) begin
      instr_start  <= 1'b0;
      instr_done   <= 1'b0;
      instr_cycles <= sat_inc(instr_cycles);
    end else begin
      phase_idx   <= next_idx;
      phase_oh    <= onehot(next_idx);
      instr_start <= wrap;
      instr_done  <= wrap;
      if (wrap) begin
        retired_cnt  <= retired_cnt + 1'b1;
        instr_cycles <= '0;
      end else begin
        instr_cycles <= sat_inc(instr_cycles);
      end
    end
  end

endmodule
